gf2_matvec_seq: RTL and testbench

Sequential, parametrised GF(2) vector-by-matrix multiplier for the CLM datapath. It computes out = (r · M) ⊕ addend over GF(2), producing LANES output bits per cycle. Operands are captured through a valid/ready handshake and the result is held until the consumer accepts it. It generalises the combinational mask-mapping multiply with a configurable output width, a configurable throughput/area trade-off, a registered output stage and an XOR-accumulate mode.

---
 rtl/gf2_matvec_if.sv | 26 ++
 rtl/gf2_matvec_seq.sv | 109 ++++++++++
 tb/tb_gf2_matvec_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_matvec_if.sv
// Operand/result handshake bundle for the GF(2) vector-by-matrix multiplier.
// master drives operands and accepts results; slave is the multiplier.
interface gf2_matvec_if #(
    parameter int D = 2,
    parameter int N = 8 + D
);
    logic           in_valid;
    logic           in_ready;
    logic [D-1:0]   r_in;
    logic [D*N-1:0] m_in;
    logic [N-1:0]   addend_in;
    logic           acc_en;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;

    modport master (
        output in_valid, r_in, m_in, addend_in, acc_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, r_in, m_in, addend_in, acc_en, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/gf2_matvec_seq.sv
// Sequential GF(2) vector-by-matrix multiplier: out = (r . M) ^ addend,
// LANES result columns per beat. Matrix rows and the addend are held in
// shift registers so each beat always reads the low LANES columns.
module gf2_matvec_seq #(
    parameter int D     = 2,
    parameter int N     = 8 + D,
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    gf2_matvec_if.slave bus
);
    localparam int NB = (N + LANES - 1) / LANES;
    localparam int PW = NB * LANES;           // row width padded to whole beats
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          beat;
    logic [D-1:0]           r_q;
    logic [D-1:0][PW-1:0]   m_q;
    logic [PW-1:0]          addend_q;
    logic                   acc_q;
    logic [N-1:0]           res_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [LANES-1:0]       lane_val;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_q;

    // Lane datapath: per lane, XOR of r-selected matrix bits plus the external addend.
    always_comb begin
        // NOTE: default assignment first so no path leaves lane_val unassigned (no latch).
        lane_val = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_val[l] = addend_q[l] & ~acc_q;
            for (int j = 0; j < D; j++) begin
                lane_val[l] = lane_val[l] ^ (r_q[j] & m_q[j][l]);
            end
        end
    end

    // Control FSM, operand capture/shift and per-beat result write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand registers are reset as well, so every register starts from a known zero.
            state       <= IDLE;
            beat        <= '0;
            r_q         <= '0;
            m_q         <= '0;
            addend_q    <= '0;
            acc_q       <= 1'b0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout: every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_q      <= bus.r_in;
                        for (int j = 0; j < D; j++) begin
                            m_q[j] <= PW'(bus.m_in[j*N +: N]);
                        end
                        addend_q   <= PW'(bus.addend_in);
                        acc_q      <= bus.acc_en;
                        beat       <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // Columns past N in the last beat have no target bit and are dropped.
                    for (int k = 0; k < N; k++) begin
                        if (beat == CW'(k / LANES)) begin
                            res_q[k] <= lane_val[k % LANES] ^ (acc_q & res_q[k]);
                        end
                    end
                    for (int j = 0; j < D; j++) begin
                        m_q[j] <= m_q[j] >> LANES;
                    end
                    addend_q <= addend_q >> LANES;
                    if (beat == LAST_BEAT) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf2_matvec_seq.sv
// Directed bench for gf2_matvec_seq: four instances (LANES 4, 1, 3, 10; D=2, N=10)
// share one operand stream and are checked against hand values and a small model.
module tb_gf2_matvec_seq;
    localparam int D  = 2;
    localparam int N  = 10;
    localparam int NI = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           acc_en;
    logic           out_ready;
    logic [D-1:0]   r_in;
    logic [D*N-1:0] m_in;
    logic [N-1:0]   addend_in;

    logic [N-1:0]   od [NI];
    logic           ov [NI];
    logic           ir [NI];

    int checks;
    int errors;

    always #5 clk = ~clk;

    gf2_matvec_if #(.D(D), .N(N)) bus [NI] ();

    function automatic int lanes_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 3;
            default: return 10;
        endcase
    endfunction

    // Required latency NB+1 for LANES 4, 1, 3, 10.
    function automatic int lat_req(input int i);
        case (i)
            0:       return 4;
            1:       return 11;
            2:       return 5;
            default: return 2;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign bus[g].in_valid  = in_valid;
        assign bus[g].r_in      = r_in;
        assign bus[g].m_in      = m_in;
        assign bus[g].addend_in = addend_in;
        assign bus[g].acc_en    = acc_en;
        assign bus[g].out_ready = out_ready;
        assign od[g] = bus[g].out_data;
        assign ov[g] = bus[g].out_valid;
        assign ir[g] = bus[g].in_ready;

        gf2_matvec_seq #(.D(D), .N(N), .LANES(lanes_of(g))) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
    end

    function automatic logic [N-1:0] model(input logic [D-1:0] r, input logic [N-1:0] m0,
                                           input logic [N-1:0] m1, input logic [N-1:0] ad);
        return ad ^ ({N{r[0]}} & m0) ^ ({N{r[1]}} & m1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s in_ready L%0d", tag, lanes_of(i)), 32'(ir[i]), 32'd1);
            check($sformatf("%s out_valid L%0d", tag, lanes_of(i)), 32'(ov[i]), 32'd0);
            check($sformatf("%s out_data L%0d", tag, lanes_of(i)), 32'(od[i]), 32'h000);
        end
    endtask

    task automatic scramble();
        r_in      = D'($urandom);
        m_in      = (D*N)'($urandom);
        addend_in = N'($urandom);
        acc_en    = 1'($urandom);
    endtask

    // One transaction on all instances; hold = cycles of back-pressure after all results are valid.
    task automatic run_txn(input string name, input logic [D-1:0] r, input logic [N-1:0] m0,
                           input logic [N-1:0] m1, input logic [N-1:0] ad, input logic acc,
                           input logic [N-1:0] exp, input int hold);
        int lat [NI];
        int waited;
        bit all_done;
        waited = 0;
        @(negedge clk);
        while (!(ir[0] && ir[1] && ir[2] && ir[3]) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({name, " ready before capture"}, 32'(ir[0] && ir[1] && ir[2] && ir[3]), 32'd1);
        in_valid  = 1'b1;
        r_in      = r;
        m_in      = {m1, m0};
        addend_in = ad;
        acc_en    = acc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        for (int i = 0; i < NI; i++) lat[i] = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (ov[i] && lat[i] == 0) lat[i] = c;
                if (lat[i] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s latency L%0d", name, lanes_of(i)), 32'(lat[i]), 32'(lat_req(i)));
            check($sformatf("%s out_data L%0d", name, lanes_of(i)), 32'(od[i]), 32'(exp));
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            scramble();
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check($sformatf("%s hold%0d out_data L%0d", name, h, lanes_of(i)), 32'(od[i]), 32'(exp));
                check($sformatf("%s hold%0d out_valid L%0d", name, h, lanes_of(i)), 32'(ov[i]), 32'd1);
                check($sformatf("%s hold%0d in_ready L%0d", name, h, lanes_of(i)), 32'(ir[i]), 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s post-accept out_valid L%0d", name, lanes_of(i)), 32'(ov[i]), 32'd0);
            check($sformatf("%s post-accept in_ready L%0d", name, lanes_of(i)), 32'(ir[i]), 32'd1);
            check($sformatf("%s post-accept out_data L%0d", name, lanes_of(i)), 32'(od[i]), 32'(exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [D-1:0] rr;
        logic [N-1:0] m0, m1, ad, exp, prev;
        logic         acc;
        bit           saw_valid;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        acc_en    = 1'b0;
        r_in      = '0;
        m_in      = '0;
        addend_in = '0;

        // Reset with no traffic.
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_reset("after reset");

        // Basic multiply, then back-pressure on the second transaction.
        run_txn("r01", 2'b01, 10'h2AB, 10'h155, 10'h000, 1'b0, 10'h2AB, 0);
        run_txn("r11 backpressure", 2'b11, 10'h2AB, 10'h155, 10'h000, 1'b0, 10'h3FE, 5);

        // Addend and accumulate.
        run_txn("addend", 2'b11, 10'h2AB, 10'h155, 10'h3FF, 1'b0, 10'h001, 0);
        run_txn("accumulate", 2'b01, 10'h2AB, 10'h155, 10'h3FF, 1'b1, 10'h2AA, 0);

        // Zero vector: result is the addend.
        run_txn("zero vector", 2'b00, 10'h3C5, 10'h19E, 10'h15A, 1'b0, 10'h15A, 0);
        prev = 10'h15A;

        // Random operands against the model, with occasional accumulate.
        for (int t = 0; t < 6; t++) begin
            rr  = D'($urandom);
            m0  = N'($urandom);
            m1  = N'($urandom);
            ad  = N'($urandom);
            acc = (t % 3 == 2);
            exp = model(rr, m0, m1, acc ? prev : ad);
            run_txn($sformatf("random%0d", t), rr, m0, m1, ad, acc, exp, 0);
            prev = exp;
        end

        // Reset in the middle of BUSY aborts the operation.
        @(negedge clk);
        in_valid  = 1'b1;
        r_in      = 2'b11;
        m_in      = {10'h155, 10'h2AB};
        addend_in = 10'h0F0;
        acc_en    = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_reset("mid-busy reset");
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (ov[i]) saw_valid = 1'b1;
        end
        check("aborted op never valid", 32'(saw_valid), 32'd0);

        // Accumulate right after reset starts from a zero result register.
        run_txn("acc after reset", 2'b01, 10'h0F0, 10'h155, 10'h3FF, 1'b1, 10'h0F0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
